// File: rtl/tri_sweep_ctrl.sv
// Triangle sweep sequencer: drives cnt lo->hi->lo for a programmed number of sweeps.
// Optional feature: define PAUSE_EN to add a pause input that freezes an active run.
module tri_sweep_ctrl #(
  parameter int W  = 4,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
`ifdef PAUSE_EN
  input  logic          pause,
`endif
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] n_sweeps,
  output logic [W-1:0]  cnt,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweeps
);

  // state | meaning
  // IDLE  | waiting for start; bad bounds raise err
  // UP    | cnt climbing toward hi_q
  // DOWN  | cnt falling toward lo_q; sweep counted on reaching lo_q
  // DONE  | one-cycle completion, done high
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  cnt_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] n_q, n_d;
  logic [SW-1:0] sweeps_d;
  logic [SW-1:0] sweeps_inc;
  logic          done_d;
  logic          err_d;
  logic          hold;

`ifdef PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign sweeps_inc = sweeps + SW'(1);
  assign dir        = (state == UP);
  assign busy       = (state == UP) || (state == DOWN);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    lo_d     = lo_q;
    hi_d     = hi_q;
    n_d      = n_q;
    sweeps_d = sweeps;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state)
      IDLE: begin
        // stop beats start when both arrive together
        if (start && !stop) begin
          if (lo < hi) begin
            lo_d     = lo;
            hi_d     = hi;
            n_d      = n_sweeps;
            cnt_d    = lo;
            sweeps_d = '0;
            state_d  = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (cnt != hi_q) begin
            cnt_d = cnt + W'(1);
          end else begin
            cnt_d   = hi_q - W'(1);
            state_d = DOWN;
          end
        end
      end

      DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (cnt != lo_q) begin
            cnt_d = cnt - W'(1);
          end else begin
            sweeps_d = sweeps_inc;
            if ((n_q != '0) && (sweeps_inc == n_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              // skip lo on the turn so the turning point is not repeated
              cnt_d   = lo_q + W'(1);
              state_d = UP;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      n_q    <= '0;
      sweeps <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      n_q    <= n_d;
      sweeps <= sweeps_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule
